fft64_frame_ctrl: RTL and testbench
===================================

// Module: fft64_frame_ctrl
// PURPOSE
//  Sequencer for the 64-point radix-4 FFT stage (3 butterfly ranks, 4-cycle ready->done).
//  Collects 64 real samples from a valid/ready stream into an input frame buffer.
//  Holds the flat input bus stable, pulses the stage's ready, then captures the real/imag
//  results on done into an output buffer. Streams the results out as 64 valid/ready beats.
//  Loading of frame n+1 overlaps unloading of frame n.
// PARAMETERS
//  DW        32  sample/result width, two's complement
//  DIGIT_REV 1   1: beat k emits result slot rev4(k) (3 base-4 digits reversed); 0: slot k
//  TIMEOUT   15  max cycles in WAIT before aborting the frame
// PORTS
//  clk          in   1      clock, all state on posedge
//  rst          in   1      asynchronous, active-low reset
//  s_valid      in   1      input sample valid
//  s_ready      out  1      controller accepts sample
//  s_data       in   DW     real input sample
//  fft_in_flat  out  64*DW  to stage data_real_in_flat; slot i = bits [DW*i +: DW]
//  fft_ready    out  1      one-cycle start pulse to stage
//  fft_done     in   1      stage done pulse
//  fft_re_flat  in   64*DW  stage data_real_out_flat
//  fft_im_flat  in   64*DW  stage data_imag_out_flat
//  m_valid      out  1      output beat valid
//  m_ready      in   1      downstream accepts beat
//  m_re, m_im   out  DW     output real/imag
//  m_index      out  6      beat number k, 0..63
//  m_last       out  1      high on beat 63
//  busy         out  1      in_state != LOAD or out_full
//  err          out  1      sticky timeout flag
//  frames_done  out  16     count of frames captured; wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (rst=0, async): in_state=LOAD, wr_cnt=0, out_full=0, rd_cnt=0, wait_cnt=0.
//   Buffers and fft_in_flat=0; s_ready=1 once rst releases; all other outputs 0.
//  Input FSM states: LOAD -> FULL -> KICK -> WAIT -> LOAD.
//  LOAD: s_ready=1. On s_valid&s_ready, write s_data to slot wr_cnt, wr_cnt++.
//   On the handshake at wr_cnt==63: wr_cnt->0, go FULL.
//  FULL: s_ready=0. Go KICK when registered out_full==0. No kick while the output buffer is
//   occupied, so capture never collides with streaming.
//  KICK: fft_ready=1 for exactly this cycle, wait_cnt=0, go WAIT.
//  WAIT: s_ready=0, wait_cnt++. fft_in_flat is driven from the input buffer and does not
//   change from the FULL entry until the WAIT exit (the stage re-samples every cycle).
//   - fft_done=1: latch all 64 re/im slots into the output buffer, out_full<=1, rd_cnt<=0,
//     frames_done++, go LOAD.
//   - wait_cnt==TIMEOUT and no done: err<=1, discard frame, go LOAD (wr_cnt=0).
//  fft_done outside WAIT: ignored, no capture, no state change.
//  Nominal KICK-to-capture latency: fft_done is seen 4 cycles after the fft_ready cycle;
//   capture is on that edge.
//  Output side: m_valid=out_full. Beat k=rd_cnt: m_re/m_im = slot (DIGIT_REV ? rev4(k) : k).
//   Example: rev4(1)=16, rev4(6)=36, rev4(63)=63. m_index=rd_cnt, m_last=(rd_cnt==63).
//   On m_valid&m_ready: rd_cnt++. On the last beat: rd_cnt=0, out_full<=0.
//   m_re/m_im/m_index are stable while m_valid=1 and m_ready=0.
//  Simultaneous events:
//   - Last output beat in the same cycle as input FULL: FULL sees out_full=1 this cycle and
//     kicks next cycle (one bubble, required).
//   - Input handshakes in LOAD are independent of output streaming.
//  err is cleared only by reset. Reset mid-frame drops all buffered data; no fft_ready is
//   issued until 64 new samples arrive.
// TESTING
//  T1 single frame: samples 0..63 = 1000,0,...,0 (impulse), m_ready=1
//   -> fft_ready pulse once; 64 beats, each m_re=1000, m_im=0; m_last on beat 63;
//      frames_done=1.
//  T2 DC frame: all samples 100, DIGIT_REV=1 -> beat 0 m_re=6400, m_im=0;
//   beats 1..63 m_re=m_im=0.
//  T3 backpressure: m_ready toggles 1,0,0,1 during T1 -> outputs hold while stalled;
//   exactly 64 accepted beats, indices 0..63 in order.
//  T4 overlap: 128 back-to-back samples, m_ready=0 until the 2nd frame is in FULL
//   -> second fft_ready is held off until 1 cycle after beat 63 of frame 1; frames_done=2.
//  T5 timeout: stage model never asserts done -> err=1 at WAIT cycle 15; back in LOAD with
//   s_ready=1; no m_valid.
//  T6 reset: rst low after 30 samples loaded, then 64 new samples
//   -> s_ready=1 right after release; one frame processed from the new samples only.

Source files
------------

// File: rtl/fft64_frame_ctrl_if.sv
// Stream-in / FFT-stage / stream-out bundle for the 64-point FFT frame sequencer.
// The controller takes the master modport and the surrounding logic takes the slave modport.
interface fft64_frame_ctrl_if #(
  parameter int DW = 32
);
  logic             s_valid;
  logic             s_ready;
  logic [DW-1:0]    s_data;
  logic [64*DW-1:0] fft_in_flat;
  logic             fft_ready;
  logic             fft_done;
  logic [64*DW-1:0] fft_re_flat;
  logic [64*DW-1:0] fft_im_flat;
  logic             m_valid;
  logic             m_ready;
  logic [DW-1:0]    m_re;
  logic [DW-1:0]    m_im;
  logic [5:0]       m_index;
  logic             m_last;
  logic             busy;
  logic             err;
  logic [15:0]      frames_done;

  modport master (
    input  s_valid, s_data, fft_done, fft_re_flat, fft_im_flat, m_ready,
    output s_ready, fft_in_flat, fft_ready, m_valid, m_re, m_im, m_index, m_last,
           busy, err, frames_done
  );

  modport slave (
    output s_valid, s_data, fft_done, fft_re_flat, fft_im_flat, m_ready,
    input  s_ready, fft_in_flat, fft_ready, m_valid, m_re, m_im, m_index, m_last,
           busy, err, frames_done
  );
endinterface

// File: rtl/fft64_frame_ctrl.sv
// Loads 64 samples, kicks the FFT stage, captures re/im on done (or aborts after TIMEOUT),
// then streams 64 result beats; m_ready stalls only the output side, loading runs on.
module fft64_frame_ctrl #(
  parameter int DW        = 32,
  parameter bit DIGIT_REV = 1'b1,
  parameter int TIMEOUT   = 15
) (
  input logic                i_clk,
  input logic                i_rst_n,
  fft64_frame_ctrl_if.master io_bus
);
  localparam int WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_LOAD, S_FULL, S_KICK, S_WAIT} state_t;

  state_t           r_state, w_state_nxt;
  logic [5:0]       r_wr_cnt;
  logic [5:0]       r_rd_cnt;
  logic [WCW-1:0]   r_wait_cnt;
  logic             r_out_full;
  logic             r_err;
  logic [15:0]      r_frames_done;
  logic [64*DW-1:0] r_in_buf;
  logic [64*DW-1:0] r_out_re;
  logic [64*DW-1:0] r_out_im;
  logic             w_s_ready;
  logic             w_load_hs;
  logic             w_fft_ready;
  logic             w_capture;
  logic             w_timeout;
  logic             w_out_hs;
  logic [5:0]       w_slot;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_LOAD;
    else          r_state <= w_state_nxt;
  end

  // FULL looks at the registered out_full, so a last beat in the same cycle costs one bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_s_ready   = 1'b0;
    w_load_hs   = 1'b0;
    w_fft_ready = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_s_ready = 1'b1;
        w_load_hs = io_bus.s_valid;
        if (io_bus.s_valid && (r_wr_cnt == 6'd63)) w_state_nxt = S_FULL;
      end
      S_FULL: begin
        if (!r_out_full) w_state_nxt = S_KICK;
      end
      S_KICK: begin
        w_fft_ready = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (io_bus.fft_done) begin
          w_capture   = 1'b1;
          w_state_nxt = S_LOAD;
        end else if (r_wait_cnt == WCW'(TIMEOUT)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  assign w_out_hs = r_out_full & io_bus.m_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_cnt      <= '0;
      r_rd_cnt      <= '0;
      r_wait_cnt    <= '0;
      r_out_full    <= 1'b0;
      r_err         <= 1'b0;
      r_frames_done <= '0;
    end else begin
      if (w_load_hs)
        r_wr_cnt <= (r_wr_cnt == 6'd63) ? 6'd0 : r_wr_cnt + 6'd1;
      if (r_state == S_KICK)      r_wait_cnt <= '0;
      else if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + WCW'(1);
      if (w_timeout) r_err <= 1'b1;
      // Kick waits for an empty output buffer, so capture and the last beat never coincide.
      if (w_capture) begin
        r_out_full    <= 1'b1;
        r_rd_cnt      <= '0;
        r_frames_done <= r_frames_done + 16'd1;
      end else if (w_out_hs) begin
        if (r_rd_cnt == 6'd63) begin
          r_rd_cnt   <= '0;
          r_out_full <= 1'b0;
        end else begin
          r_rd_cnt <= r_rd_cnt + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_buf <= '0;
      r_out_re <= '0;
      r_out_im <= '0;
    end else begin
      if (w_load_hs) r_in_buf[DW*r_wr_cnt +: DW] <= io_bus.s_data;
      if (w_capture) begin
        r_out_re <= io_bus.fft_re_flat;
        r_out_im <= io_bus.fft_im_flat;
      end
    end
  end

  // The stage emits bins in base-4 digit-reversed slot order.
  assign w_slot = DIGIT_REV ? {r_rd_cnt[1:0], r_rd_cnt[3:2], r_rd_cnt[5:4]} : r_rd_cnt;

  assign io_bus.s_ready     = w_s_ready;
  assign io_bus.fft_in_flat = r_in_buf;
  assign io_bus.fft_ready   = w_fft_ready;
  assign io_bus.m_valid     = r_out_full;
  assign io_bus.m_re        = r_out_re[DW*w_slot +: DW];
  assign io_bus.m_im        = r_out_im[DW*w_slot +: DW];
  assign io_bus.m_index     = r_rd_cnt;
  assign io_bus.m_last      = (r_rd_cnt == 6'd63);
  assign io_bus.busy        = (r_state != S_LOAD) | r_out_full;
  assign io_bus.err         = r_err;
  assign io_bus.frames_done = r_frames_done;
endmodule

// File: tb/tb_fft64_frame_ctrl.sv
// Bench for fft64_frame_ctrl: a DFT-based stage model feeds digit-reversed results and a
// scoreboard queue holds the natural-order beats each frame must produce.
`timescale 1ns/1ps
module tb_fft64_frame_ctrl;
  localparam int DW      = 32;
  localparam int TIMEOUT = 15;

  typedef struct {
    int re;
    int im;
    int idx;
    bit last;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft64_frame_ctrl_if #(.DW(DW)) bus ();

  fft64_frame_ctrl #(.DW(DW), .DIGIT_REV(1'b1), .TIMEOUT(TIMEOUT)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_bus (bus)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  beat_t sbq[$];
  int    frame[64];
  real   cos_t[64];
  real   sin_t[64];
  int    exp_frames = 0;

  int    kick_cnt    = 0;
  int    kick_cyc    = 0;
  int    last_cyc    = 0;
  int    kick_gap    = 0;
  int    mv_rise_cyc = 0;
  bit    stage_en    = 1'b1;
  logic  stage_done  = 1'b0;
  logic  force_done  = 1'b0;
  int    m_mode      = 0;
  int    m_phase     = 0;

  assign bus.fft_done = stage_done | force_done;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rev4(input int k);
    logic [5:0] v;
    v = 6'(k);
    return int'({v[1:0], v[3:2], v[5:4]});
  endfunction

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  task automatic dft(input int x[64], output int re[64], output int im[64]);
    for (int k = 0; k < 64; k++) begin
      real sr = 0.0;
      real si = 0.0;
      for (int i = 0; i < 64; i++) begin
        sr = sr + real'(x[i]) * cos_t[(i * k) % 64];
        si = si - real'(x[i]) * sin_t[(i * k) % 64];
      end
      re[k] = rnd(sr);
      im[k] = rnd(si);
    end
  endtask

  // m_ready driver: 0 always ready, 1 repeating 1,0,0,1, 2 never ready
  always @(posedge clk) begin
    #1;
    case (m_mode)
      0:       bus.m_ready = 1'b1;
      1: begin
        bus.m_ready = ((m_phase % 4) == 0) || ((m_phase % 4) == 3);
        m_phase++;
      end
      default: bus.m_ready = 1'b0;
    endcase
  end

  // Stage model: done 4 cycles after the ready pulse, bins placed at digit-reversed slots.
  logic [64*DW-1:0] st_in;
  int   st_cnt   = 0;
  logic prev_rdy = 1'b0;
  int   st_x[64];
  int   st_re[64];
  int   st_im[64];
  always @(negedge clk) begin
    stage_done = 1'b0;
    if (bus.fft_ready === 1'b1) begin
      kick_cnt++;
      kick_cyc = cyc;
      kick_gap = cyc - last_cyc;
      n_tests++;
      if (prev_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL fft_ready_width: high on consecutive cycles at cyc %0d, required one-cycle pulse", cyc);
      end
      st_in = bus.fft_in_flat;
      if (stage_en) st_cnt = 4;
    end else if (st_cnt > 0) begin
      st_cnt--;
      if (st_cnt == 0) begin
        n_tests++;
        if (bus.fft_in_flat !== st_in) begin
          n_fail++;
          $display("FAIL fft_in_hold: fft_in_flat changed between kick and done");
        end
        for (int s = 0; s < 64; s++) st_x[s] = $signed(st_in[s*DW +: DW]);
        dft(st_x, st_re, st_im);
        for (int s = 0; s < 64; s++) begin
          bus.fft_re_flat[s*DW +: DW] = st_re[rev4(s)];
          bus.fft_im_flat[s*DW +: DW] = st_im[rev4(s)];
        end
        stage_done = 1'b1;
      end
    end
    prev_rdy = bus.fft_ready;
  end

  // Output monitor: scoreboard pop on each accepted beat, hold check on stalled beats.
  beat_t      exp_b;
  logic [DW-1:0] prv_re, prv_im;
  logic [5:0] prv_idx;
  bit         prv_stall = 1'b0;
  bit         prv_valid = 1'b0;
  always @(negedge clk) begin
    if (prv_stall) begin
      n_tests++;
      if ({bus.m_valid, bus.m_re, bus.m_im, bus.m_index} !== {1'b1, prv_re, prv_im, prv_idx}) begin
        n_fail++;
        $display("FAIL stall_hold: got v=%0b re=%0d im=%0d idx=%0d, required v=1 re=%0d im=%0d idx=%0d",
                 bus.m_valid, $signed(bus.m_re), $signed(bus.m_im), bus.m_index,
                 $signed(prv_re), $signed(prv_im), prv_idx);
      end
    end
    if (bus.m_valid && !prv_valid) mv_rise_cyc = cyc;
    if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
      n_tests++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: idx=%0d re=%0d with no beat expected", bus.m_index, $signed(bus.m_re));
      end else begin
        exp_b = sbq.pop_front();
        if ($signed(bus.m_re) !== exp_b.re || $signed(bus.m_im) !== exp_b.im ||
            bus.m_index !== 6'(exp_b.idx) || bus.m_last !== exp_b.last) begin
          n_fail++;
          $display("FAIL beat: got re=%0d im=%0d idx=%0d last=%0b, required re=%0d im=%0d idx=%0d last=%0b",
                   $signed(bus.m_re), $signed(bus.m_im), bus.m_index, bus.m_last,
                   exp_b.re, exp_b.im, exp_b.idx, exp_b.last);
        end
      end
      if (bus.m_last) last_cyc = cyc;
    end
    prv_stall = bus.m_valid && !bus.m_ready;
    prv_valid = bus.m_valid;
    prv_re    = bus.m_re;
    prv_im    = bus.m_im;
    prv_idx   = bus.m_index;
  end

  task automatic push_dft();
    int    re[64];
    int    im[64];
    beat_t b;
    dft(frame, re, im);
    for (int k = 0; k < 64; k++) begin
      b.re = re[k]; b.im = im[k]; b.idx = k; b.last = (k == 63);
      sbq.push_back(b);
    end
  endtask

  task automatic rand_frame();
    for (int i = 0; i < 64; i++) frame[i] = int'($urandom_range(0, 4000)) - 2000;
  endtask

  // Drives frame[first .. first+n-1]; entered and left just after a rising edge.
  task automatic send_frame(input int first, input int n, input int gap, output bit ok);
    int i     = first;
    int guard = 0;
    bit acc;
    while (i < first + n && guard < 4000) begin
      bus.s_valid = (gap == 0) || ($urandom_range(0, gap) != 0);
      bus.s_data  = frame[i];
      @(negedge clk);
      acc = bus.s_valid && bus.s_ready;
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
    end
    bus.s_valid = 1'b0;
    ok = (i == first + n);
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    int c = 0;
    while ((sbq.size() != 0 || bus.m_valid) && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    ok = (sbq.size() == 0) && !bus.m_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({bus.fft_ready, bus.m_valid, bus.err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_active: fft_ready/m_valid/err=%b required 000", {bus.fft_ready, bus.m_valid, bus.err});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({bus.s_ready, bus.m_valid, bus.fft_ready, bus.busy, bus.err, bus.m_last} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_ctrl: s_ready,m_valid,fft_ready,busy,err,m_last=%b required 100000",
               {bus.s_ready, bus.m_valid, bus.fft_ready, bus.busy, bus.err, bus.m_last});
    end
    n_tests++;
    if (bus.frames_done !== 16'd0 || bus.m_index !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_counts: frames_done=%0d m_index=%0d required 0 0", bus.frames_done, bus.m_index);
    end
    n_tests++;
    if (bus.fft_in_flat !== '0 || bus.m_re !== '0 || bus.m_im !== '0) begin
      n_fail++;
      $display("FAIL reset_data: fft_in_flat/m_re/m_im not all zero");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    beat_t b;
    bit    ok;
    int    k0 = kick_cnt;
    for (int i = 0; i < 64; i++) frame[i] = (i == 0) ? 1000 : 0;
    for (int k = 0; k < 64; k++) begin
      b.re = 1000; b.im = 0; b.idx = k; b.last = (k == 63);
      sbq.push_back(b);
    end
    send_frame(0, 64, 0, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL single_load: samples not accepted in budget"); end
    wait_drain(500, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL single_drain: %0d beats still expected", sbq.size()); end
    exp_frames++;
    n_tests++;
    if (kick_cnt - k0 != 1 || bus.frames_done !== 16'(exp_frames)) begin
      n_fail++;
      $display("FAIL single_counts: kicks=%0d frames_done=%0d required 1 %0d", kick_cnt - k0, bus.frames_done, exp_frames);
    end
    n_tests++;
    if (mv_rise_cyc - kick_cyc != 5) begin
      n_fail++;
      $display("FAIL kick_to_valid: %0d cycles required 5", mv_rise_cyc - kick_cyc);
    end
  endtask

  task automatic test_dc();
    beat_t b;
    bit    ok;
    for (int i = 0; i < 64; i++) frame[i] = 100;
    for (int k = 0; k < 64; k++) begin
      b.re = (k == 0) ? 6400 : 0; b.im = 0; b.idx = k; b.last = (k == 63);
      sbq.push_back(b);
    end
    send_frame(0, 64, 3, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL dc_load: samples not accepted in budget"); end
    wait_drain(500, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL dc_drain: %0d beats still expected", sbq.size()); end
    exp_frames++;
    n_tests++;
    if (bus.frames_done !== 16'(exp_frames)) begin
      n_fail++;
      $display("FAIL dc_frames: frames_done=%0d required %0d", bus.frames_done, exp_frames);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    rand_frame();
    push_dft();
    m_mode = 1;
    send_frame(0, 64, 0, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL bp_load: samples not accepted in budget"); end
    wait_drain(800, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL bp_drain: %0d beats still expected", sbq.size()); end
    m_mode = 0;
    exp_frames++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int k0;
    m_mode = 2;
    rand_frame();
    push_dft();
    send_frame(0, 64, 0, ok);
    rand_frame();
    push_dft();
    send_frame(0, 64, 0, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL b2b_load: second frame not accepted in budget"); end
    k0 = kick_cnt;
    repeat (10) @(posedge clk);
    #1;
    n_tests++;
    if (kick_cnt != k0 || {bus.s_ready, bus.busy, bus.m_valid} !== 3'b011) begin
      n_fail++;
      $display("FAIL b2b_hold: kicks=%0d s_ready,busy,m_valid=%b required 0 011", kick_cnt - k0,
               {bus.s_ready, bus.busy, bus.m_valid});
    end
    m_mode = 0;
    wait_drain(800, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL b2b_drain: %0d beats still expected", sbq.size()); end
    n_tests++;
    if (kick_gap != 2) begin
      n_fail++;
      $display("FAIL b2b_kick_gap: kick %0d cycles after last beat, required 2", kick_gap);
    end
    exp_frames += 2;
    n_tests++;
    if (bus.frames_done !== 16'(exp_frames)) begin
      n_fail++;
      $display("FAIL b2b_frames: frames_done=%0d required %0d", bus.frames_done, exp_frames);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    bit seen = 1'b0;
    int c = 0;
    stage_en = 1'b0;
    rand_frame();
    send_frame(0, 64, 0, ok);
    while (c < 80 && !seen) begin
      @(negedge clk);
      c++;
      if (bus.err === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (!seen || (cyc - kick_cyc) != TIMEOUT + 2) begin
      n_fail++;
      $display("FAIL timeout_err: seen=%0b at %0d cycles after kick, required 1 at %0d", seen, cyc - kick_cyc, TIMEOUT + 2);
    end
    n_tests++;
    if ({bus.s_ready, bus.busy, bus.m_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL timeout_state: s_ready,busy,m_valid=%b required 100", {bus.s_ready, bus.busy, bus.m_valid});
    end
    @(posedge clk); #1;
    force_done = 1'b1;
    @(posedge clk); #1;
    force_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (bus.frames_done !== 16'(exp_frames) || bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stray_done: frames_done=%0d m_valid=%0b s_ready=%0b required %0d 0 1",
               bus.frames_done, bus.m_valid, bus.s_ready, exp_frames);
    end
    stage_en = 1'b1;
    rand_frame();
    push_dft();
    send_frame(0, 64, 0, ok);
    wait_drain(500, ok);
    exp_frames++;
    n_tests++;
    if (!ok || bus.err !== 1'b1 || bus.frames_done !== 16'(exp_frames)) begin
      n_fail++;
      $display("FAIL err_sticky: drained=%0b err=%0b frames_done=%0d required 1 1 %0d", ok, bus.err, bus.frames_done, exp_frames);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int k0;
    rand_frame();
    send_frame(0, 30, 0, ok);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.s_ready !== 1'b1 || bus.err !== 1'b0 || bus.frames_done !== 16'd0 || bus.fft_in_flat !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: s_ready=%0b err=%0b frames_done=%0d buf_zero=%0b required 1 0 0 1",
               bus.s_ready, bus.err, bus.frames_done, (bus.fft_in_flat == '0));
    end
    @(posedge clk); #1;
    exp_frames = 0;
    k0 = kick_cnt;
    rand_frame();
    push_dft();
    send_frame(0, 63, 0, ok);
    repeat (8) @(posedge clk);
    #1;
    n_tests++;
    if (kick_cnt != k0) begin
      n_fail++;
      $display("FAIL reset_no_kick: %0d kicks before 64 new samples, required 0", kick_cnt - k0);
    end
    send_frame(63, 1, 0, ok);
    wait_drain(500, ok);
    exp_frames++;
    n_tests++;
    if (!ok || kick_cnt - k0 != 1 || bus.frames_done !== 16'(exp_frames)) begin
      n_fail++;
      $display("FAIL reset_frame: drained=%0b kicks=%0d frames_done=%0d required 1 1 %0d",
               ok, kick_cnt - k0, bus.frames_done, exp_frames);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int j = 0; j < 64; j++) begin
      cos_t[j] = $cos(2.0 * 3.14159265358979 * real'(j) / 64.0);
      sin_t[j] = $sin(2.0 * 3.14159265358979 * real'(j) / 64.0);
    end
    bus.s_valid     = 1'b0;
    bus.s_data      = '0;
    bus.m_ready     = 1'b1;
    bus.fft_re_flat = '0;
    bus.fft_im_flat = '0;
    test_reset();
    test_single();
    test_dc();
    test_backpressure();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
